// File: rtl/cbd84_down_counter_pkg.sv
// Shared constants for the cbd84 down-counter family: default width,
// underflow-mode encodings and an all-ones helper.
package cbd84_down_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 16;

  // AUTO_RELOAD encodings
  localparam int AR_WRAP   = 0;
  localparam int AR_RELOAD = 1;

  function automatic logic [MAX_WIDTH-1:0] all_ones(input int width);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/cbd84_down_chain.sv
// Ripple-borrow cascade of cbd84_down_counter stages forming one wide down counter;
// stage 0 is least significant, and each stage's borrow-out enables the next.
module cbd84_down_chain
  import cbd84_down_counter_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = 2
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    EN,
  input  logic                    LD,
  input  logic [STAGES*WIDTH-1:0] D,
  output logic [STAGES*WIDTH-1:0] Q,
  output logic                    BO,
  output logic                    TCP
);

  logic [STAGES:0]   w_borrow;
  logic [STAGES-1:0] w_tcp;

  assign w_borrow[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      cbd84_down_counter #(
        .WIDTH       (WIDTH),
        .AUTO_RELOAD (AR_WRAP)
      ) u_stage (
        .CLK  (CLK),
        .RSTN (RSTN),
        .EN   (EN),
        .BI   (w_borrow[gi]),
        .LD   (LD),
        .D    (D[gi*WIDTH +: WIDTH]),
        .Q    (Q[gi*WIDTH +: WIDTH]),
        .BO   (w_borrow[gi+1]),
        .TCP  (w_tcp[gi])
      );
    end
  endgenerate

  // The whole chain underflows exactly when the top stage does
  assign BO  = w_borrow[STAGES];
  assign TCP = w_tcp[STAGES-1];

endmodule

// File: rtl/cbd84_down_counter.sv
// Cascadable synchronous down counter with a parallel load, an optional reload on
// underflow, a combinational borrow-out and a registered terminal-count pulse.
module cbd84_down_counter
  import cbd84_down_counter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int AUTO_RELOAD = AR_WRAP
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             EN,
  input  logic             BI,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             BO,
  output logic             TCP
);

  localparam logic [MAX_WIDTH-1:0] ONES_FULL = all_ones(WIDTH);
  localparam logic [WIDTH-1:0]     ONES      = ONES_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] r_q;
  logic             r_tcp;
  logic             w_dec;
  logic             w_zero;
  logic [WIDTH-1:0] w_wrap_val;

  assign w_dec      = EN && BI;
  assign w_zero     = (r_q == '0);
  assign w_wrap_val = (AUTO_RELOAD == AR_RELOAD) ? D : ONES;

  // LD is deliberately left out so that the cascade sees only count state
  assign BO = w_dec && w_zero;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_q   <= '0;
      r_tcp <= 1'b0;
    end else if (LD) begin
      r_q   <= D;
      r_tcp <= 1'b0;
    end else if (w_dec) begin
      if (w_zero) begin
        r_q   <= w_wrap_val;
        r_tcp <= 1'b1;
      end else begin
        r_q   <= r_q - 1'b1;
        r_tcp <= 1'b0;
      end
    end else begin
      r_tcp <= 1'b0;
    end
  end

  assign Q   = r_q;
  assign TCP = r_tcp;

endmodule

// File: tb/tb_cbd84_down_counter.sv
// Scoreboard bench: a wrapping counter, a reloading counter and a two-stage chain
// run side by side against behavioural models.
module tb_cbd84_down_counter;

  logic       clk = 1'b0;
  logic       RSTN, EN, BI, LD;
  logic [3:0] D;
  logic [7:0] CD;

  logic [3:0] q_w, q_r;
  logic       bo_w, bo_r, tcp_w, tcp_r;
  logic [7:0] q_c;
  logic       bo_c, tcp_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] q_w;
    logic       tcp_w;
    logic [3:0] q_r;
    logic       tcp_r;
    logic [7:0] q_c;
    logic       tcp_c;
  } exp_t;

  exp_t exp_q[$];

  // behavioural model state
  logic [3:0] m_w = 4'd0, m_r = 4'd0;
  logic [7:0] m_c = 8'd0;

  always #5 clk = ~clk;

  cbd84_down_counter #(.WIDTH(4), .AUTO_RELOAD(0)) dut (
    .CLK(clk), .RSTN(RSTN), .EN(EN), .BI(BI), .LD(LD), .D(D),
    .Q(q_w), .BO(bo_w), .TCP(tcp_w)
  );

  cbd84_down_counter #(.WIDTH(4), .AUTO_RELOAD(1)) dut_ar (
    .CLK(clk), .RSTN(RSTN), .EN(EN), .BI(BI), .LD(LD), .D(D),
    .Q(q_r), .BO(bo_r), .TCP(tcp_r)
  );

  cbd84_down_chain #(.WIDTH(4), .STAGES(2)) u_chain (
    .CLK(clk), .RSTN(RSTN), .EN(EN), .LD(LD), .D(CD),
    .Q(q_c), .BO(bo_c), .TCP(tcp_c)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: check borrow-outs before the edge, predict, compare after.
  task automatic step(input logic rstn, input logic en, input logic bi,
                      input logic ld, input logic [7:0] d, input string tag);
    exp_t e;
    exp_t got;
    @(negedge clk);
    RSTN = rstn; EN = en; BI = bi; LD = ld; D = d[3:0]; CD = d;
    #1;
    check_val({tag, ":bo_w"}, 32'(bo_w), 32'(en && bi && (m_w == 4'd0)));
    check_val({tag, ":bo_r"}, 32'(bo_r), 32'(en && bi && (m_r == 4'd0)));
    check_val({tag, ":bo_c"}, 32'(bo_c), 32'(en && (m_c == 8'd0)));

    e.tcp_w = 1'b0; e.tcp_r = 1'b0; e.tcp_c = 1'b0;
    if (!rstn) begin
      m_w = 4'd0; m_r = 4'd0; m_c = 8'd0;
    end else if (ld) begin
      m_w = d[3:0]; m_r = d[3:0]; m_c = d;
    end else begin
      if (en && bi) begin
        e.tcp_w = (m_w == 4'd0);
        e.tcp_r = (m_r == 4'd0);
        m_w = m_w - 4'd1;
        m_r = (m_r == 4'd0) ? d[3:0] : m_r - 4'd1;
      end
      if (en) begin
        e.tcp_c = (m_c == 8'd0);
        m_c = m_c - 8'd1;
      end
    end
    e.q_w = m_w; e.q_r = m_r; e.q_c = m_c;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val({tag, ":queue_empty"}, 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      check_val({tag, ":q_w"},   32'(q_w),   32'(got.q_w));
      check_val({tag, ":tcp_w"}, 32'(tcp_w), 32'(got.tcp_w));
      check_val({tag, ":q_r"},   32'(q_r),   32'(got.q_r));
      check_val({tag, ":tcp_r"}, 32'(tcp_r), 32'(got.tcp_r));
      check_val({tag, ":q_c"},   32'(q_c),   32'(got.q_c));
      check_val({tag, ":tcp_c"}, 32'(tcp_c), 32'(got.tcp_c));
    end
  endtask

  initial begin
    RSTN = 1'b0; EN = 1'b0; BI = 1'b0; LD = 1'b0; D = '0; CD = '0;

    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, "reset");
    check_val("reset_q_const", 32'(q_w), 32'd0);
    check_val("reset_chain_const", 32'(q_c), 32'd0);

    // free run: 0 -> 15 -> ... -> 0 -> 15, chain 0 -> 255 -> 254 ...
    for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, "count");
    check_val("wrap_q_const", 32'(q_w), 32'd15);
    check_val("wrap_tcp_const", 32'(tcp_w), 32'd1);
    check_val("chain_const", 32'(q_c), 32'd239);

    // hold cases
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h3c, "hold_en");
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h3c, "hold_bi");

    // load over count, then count down
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h09, "load9");
    check_val("load9_const", 32'(q_w), 32'd9);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, "after_load");
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, "after_load");
    check_val("load_count_const", 32'(q_w), 32'd7);

    // load wins over underflow
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h01, "load1");
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, "to_zero");
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h03, "ld_vs_uf");
    check_val("ld_vs_uf_tcp_const", 32'(tcp_w), 32'd0);

    // auto-reload: 2, 1, 0, 5, 4
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h02, "ar_load2");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h05, "ar_count");
    check_val("ar_const", 32'(q_r), 32'd4);

    // reset beats load mid-count, then count resumes at 15
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h07, "load7");
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h07, "rst_vs_ld");
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, "resume");
    check_val("resume_const", 32'(q_w), 32'd15);

    // randomised traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 99) >= 3), ($urandom_range(0, 99) < 80),
           ($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 10),
           8'($urandom_range(0, 255)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
